// File: rtl/ioctl_dn_buffer.sv
// rtl/ioctl_dn_buffer.sv - rate-matching FIFO between the ioctl byte stream and the system download port
module ioctl_dn_buffer #(
    parameter int DEPTH    = 8,
    parameter int HEADROOM = 2
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce_drain,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic [23:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [7:0]  dn_index,
    output logic        dn_busy,
    output logic [24:0] dn_count,
    output logic [7:0]  dn_sum,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] OCC_HIGH = (AW+1)'(DEPTH - HEADROOM);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH} state_t;

    state_t       state_q, state_d;
    logic [AW:0]  occ_q, occ_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]  mem_q [DEPTH];
    logic         dn_wr_q, dn_wr_d;
    logic [23:0]  dn_addr_q, dn_addr_d;
    logic [7:0]   dn_data_q, dn_data_d;
    logic [7:0]   dn_index_q, dn_index_d;
    logic [24:0]  dn_count_q, dn_count_d;
    logic [7:0]   dn_sum_q, dn_sum_d;
    logic         overflow_q, overflow_d;
    logic         push, pop, drop, wr_req;
    logic         addr_msb_unused;

    assign addr_msb_unused = ioctl_addr[24];

    always_comb begin
        state_d    = state_q;
        occ_d      = occ_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        dn_wr_d    = 1'b0;
        dn_addr_d  = dn_addr_q;
        dn_data_d  = dn_data_q;
        dn_index_d = dn_index_q;
        dn_count_d = dn_count_q;
        dn_sum_d   = dn_sum_q;
        overflow_d = overflow_q;

        wr_req = ioctl_wr && ioctl_download;
        pop    = (state_q != S_IDLE) && ce_drain && (occ_q != '0);
        // A pop in the same cycle frees the slot, so a write at full is still taken.
        push   = wr_req && (state_q == S_LOAD) && ((occ_q != OCC_FULL) || pop);
        drop   = wr_req && !push;

        case (state_q)
            S_IDLE:  if (ioctl_download) state_d = S_LOAD;
            S_LOAD:  if (!ioctl_download) state_d = S_FLUSH;
            S_FLUSH: if (occ_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        occ_d = occ_q + (AW+1)'(push) - (AW+1)'(pop);
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            dn_wr_d   = 1'b1;
            dn_addr_d = mem_q[rd_ptr_q][31:8];
            dn_data_d = mem_q[rd_ptr_q][7:0];
        end

        if (dn_wr_q) begin
            dn_count_d = dn_count_q + 25'd1;
            dn_sum_d   = dn_sum_q + dn_data_q;
        end

        if ((state_q == S_IDLE) && ioctl_download) begin
            dn_index_d = ioctl_index;
            dn_count_d = '0;
            dn_sum_d   = '0;
            overflow_d = 1'b0;
        end
        // A drop on the session-start cycle must still be reported.
        if (drop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            occ_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            dn_wr_q    <= 1'b0;
            dn_addr_q  <= '0;
            dn_data_q  <= '0;
            dn_index_q <= '0;
            dn_count_q <= '0;
            dn_sum_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            dn_wr_q    <= dn_wr_d;
            dn_addr_q  <= dn_addr_d;
            dn_data_q  <= dn_data_d;
            dn_index_q <= dn_index_d;
            dn_count_q <= dn_count_d;
            dn_sum_q   <= dn_sum_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem_q[wr_ptr_q] <= {ioctl_addr[23:0], ioctl_dout};
    end

    assign ioctl_wait = (state_q == S_FLUSH) || ((state_q == S_IDLE) && ioctl_download) ||
                        (occ_q >= OCC_HIGH);
    assign dn_busy    = (state_q != S_IDLE);
    assign dn_wr      = dn_wr_q;
    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign dn_index   = dn_index_q;
    assign dn_count   = dn_count_q;
    assign dn_sum     = dn_sum_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_ioctl_dn_buffer.sv
// tb/tb_ioctl_dn_buffer.sv - randomized self-checking bench for ioctl_dn_buffer
module tb_ioctl_dn_buffer;
    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce_drain = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic        ioctl_wait, dn_wr, dn_busy, overflow;
    logic [23:0] dn_addr;
    logic [7:0]  dn_data, dn_index, dn_sum;
    logic [24:0] dn_count;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc_n = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [23:0] stim_addr[64];
    logic [7:0]  stim_data[64];
    int s_occ_at_wait, s_gap, s_lat;
    bit s_timeout;

    ioctl_dn_buffer #(.DEPTH(8), .HEADROOM(2)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce_drain(ce_drain),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
        .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr), .dn_index(dn_index),
        .dn_busy(dn_busy), .dn_count(dn_count), .dn_sum(dn_sum), .overflow(overflow)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc_n <= cyc_n + 1;
    always @(negedge clk_sys) if (reset_n && dn_wr) got_q.push_back({dn_addr, dn_data});

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic ce_value(input int mode);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc_n % 4) == 0;
            2:       return 1'($urandom);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int stream_diff();
        if (got_q.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] exp_sum(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(stim_data[i]);
        return 8'(s);
    endfunction

    // Harness that honours ioctl_wait; records occupancy at first wait, latency and busy tail.
    task automatic run_session(input logic [7:0] idx, input int n, input int ce_mode);
        int nwr, ndn, occ, k, last_wr, first_wr, first_dn;
        bit done;
        nwr = 0; ndn = 0; k = 0; last_wr = -100; first_wr = -1; first_dn = -1; done = 0;
        s_occ_at_wait = -1; s_gap = -1; s_lat = -1; s_timeout = 0;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back({stim_addr[i], stim_data[i]});
        ioctl_index = idx;
        ioctl_download = 1'b1;
        tick();
        ioctl_index = 8'($urandom);
        while (nwr < n && k < 3000) begin
            ndn += int'(dn_wr);
            if (dn_wr && first_dn < 0) first_dn = k;
            occ = nwr - ndn;
            if (ioctl_wait && s_occ_at_wait < 0) s_occ_at_wait = occ;
            ce_drain   = ce_value(ce_mode);
            ioctl_wr   = !ioctl_wait;
            ioctl_addr = {1'($urandom), stim_addr[nwr]};
            ioctl_dout = stim_data[nwr];
            if (ioctl_wr && first_wr < 0) first_wr = k;
            tick();
            if (ioctl_wr) nwr++;
            k++;
        end
        if (nwr < n) s_timeout = 1;
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        k = 0;
        while (!done && k < 3000) begin
            if (dn_wr) last_wr = k;
            if (!dn_busy) begin
                s_gap = k - last_wr;
                done = 1;
            end else begin
                ce_drain = ce_value(ce_mode);
                tick();
                k++;
            end
        end
        if (!done) s_timeout = 1;
        if (first_dn >= 0 && first_wr >= 0) s_lat = first_dn - first_wr;
        ce_drain = 1'b0;
    endtask

    task automatic drain_to_idle(output bit ok);
        int k = 0;
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        ce_drain = 1'b1;
        while (dn_busy && k < 500) begin tick(); k++; end
        ok = !dn_busy;
        ce_drain = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        tests_run++;
        if ({dn_wr, dn_busy, overflow, dn_addr, dn_data, dn_index, dn_count, dn_sum} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got wr=%b busy=%b ovf=%b addr=%h data=%h idx=%h cnt=%0d sum=%h, required all zero",
                     dn_wr, dn_busy, overflow, dn_addr, dn_data, dn_index, dn_count, dn_sum);
        end
        tests_run++;
        if (ioctl_wait !== 1'b0) begin
            tests_failed++; $display("FAIL reset_wait: got %b required 0", ioctl_wait);
        end
        @(posedge clk_sys); #1; reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        for (int i = 0; i < 16; i++) begin stim_addr[i] = 24'(i); stim_data[i] = 8'(i); end
        run_session(8'h01, 16, 0);
        tests_run++;
        if (s_timeout) begin tests_failed++; $display("FAIL basic_timeout: session did not complete"); end
        tests_run++;
        if (stream_diff() != -1) begin
            tests_failed++;
            $display("FAIL basic_stream: got %0d bytes required %0d, diff at %0d", got_q.size(), exp_q.size(), stream_diff());
        end
        tests_run++;
        if (dn_count !== 25'd16 || dn_sum !== 8'h78 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_totals: got cnt=%0d sum=%h ovf=%b required 16 78 0", dn_count, dn_sum, overflow);
        end
        tests_run++;
        if (dn_index !== 8'h01) begin tests_failed++; $display("FAIL basic_index: got %h required 01", dn_index); end
        tests_run++;
        if (s_gap !== 1) begin tests_failed++; $display("FAIL basic_busy_tail: got %0d cycles required 1", s_gap); end
        tests_run++;
        if (s_lat !== 2) begin tests_failed++; $display("FAIL basic_latency: got %0d cycles required 2", s_lat); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 64; i++) begin stim_addr[i] = 24'($urandom); stim_data[i] = 8'($urandom); end
        run_session(8'($urandom), 64, 1);
        tests_run++;
        if (s_timeout) begin tests_failed++; $display("FAIL bp_timeout: session did not complete"); end
        tests_run++;
        if (s_occ_at_wait !== 6) begin
            tests_failed++; $display("FAIL bp_wait_level: wait first rose at occupancy %0d required 6", s_occ_at_wait);
        end
        tests_run++;
        if (stream_diff() != -1) begin
            tests_failed++; $display("FAIL bp_stream: got %0d bytes required %0d", got_q.size(), exp_q.size());
        end
        tests_run++;
        if (dn_count !== 25'd64 || overflow !== 1'b0 || dn_sum !== exp_sum(64)) begin
            tests_failed++;
            $display("FAIL bp_totals: got cnt=%0d ovf=%b sum=%h required 64 0 %h", dn_count, overflow, dn_sum, exp_sum(64));
        end
    endtask

    task automatic test_overflow();
        bit ok;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 10; i++) begin stim_addr[i] = 24'($urandom); stim_data[i] = 8'($urandom); end
        for (int i = 0; i < 8; i++) exp_q.push_back({stim_addr[i], stim_data[i]});
        ce_drain = 1'b0;
        ioctl_index = 8'($urandom);
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = {1'b0, stim_addr[i]}; ioctl_dout = stim_data[i];
            tick();
        end
        ioctl_wr = 1'b0;
        tests_run++;
        if (overflow !== 1'b1 || ioctl_wait !== 1'b1) begin
            tests_failed++; $display("FAIL ovf_flag: got ovf=%b wait=%b required 1 1", overflow, ioctl_wait);
        end
        drain_to_idle(ok);
        tests_run++;
        if (!ok || stream_diff() != -1 || dn_count !== 25'd8) begin
            tests_failed++;
            $display("FAIL ovf_drain: got %0d bytes cnt=%0d idle=%b required 8 8 1", got_q.size(), dn_count, ok);
        end
        tests_run++;
        if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
    endtask

    task automatic test_full_pop();
        bit ok;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            stim_addr[i] = 24'($urandom); stim_data[i] = 8'($urandom);
            exp_q.push_back({stim_addr[i], stim_data[i]});
        end
        ce_drain = 1'b0;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            ce_drain = (i == 8);
            ioctl_wr = 1'b1; ioctl_addr = {1'b1, stim_addr[i]}; ioctl_dout = stim_data[i];
            tick();
        end
        ioctl_wr = 1'b0; ce_drain = 1'b0;
        tick();
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL fullpop_ovf: got %b required 0", overflow); end
        drain_to_idle(ok);
        tests_run++;
        if (!ok || stream_diff() != -1 || dn_count !== 25'd9) begin
            tests_failed++;
            $display("FAIL fullpop_drain: got %0d bytes cnt=%0d required 9 9", got_q.size(), dn_count);
        end
    endtask

    task automatic test_checksum();
        int n;
        stim_addr[0] = 24'h000100; stim_data[0] = 8'hFF;
        stim_addr[1] = 24'h000101; stim_data[1] = 8'h02;
        run_session(8'h22, 2, 0);
        tests_run++;
        if (s_timeout || dn_sum !== 8'h01 || dn_count !== 25'd2) begin
            tests_failed++; $display("FAIL sum_wrap: got sum=%h cnt=%0d required 01 2", dn_sum, dn_count);
        end
        n = $urandom_range(5, 40);
        for (int i = 0; i < n; i++) begin stim_addr[i] = 24'($urandom); stim_data[i] = 8'($urandom); end
        run_session(8'($urandom), n, 2);
        tests_run++;
        if (s_timeout || stream_diff() != -1 || dn_sum !== exp_sum(n) || dn_count !== 25'(n)) begin
            tests_failed++;
            $display("FAIL sum_random: got sum=%h cnt=%0d bytes=%0d required %h %0d", dn_sum, dn_count, got_q.size(), exp_sum(n), n);
        end
    endtask

    task automatic test_refire();
        int idle_n, ndn, k, wait_bad;
        bit done, ok;
        logic [7:0] new_idx;
        got_q.delete(); exp_q.delete();
        idle_n = 0; ndn = 0; k = 0; wait_bad = 0; done = 0;
        new_idx = 8'($urandom) | 8'h40;
        ce_drain = 1'b0;
        ioctl_index = 8'h11;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            stim_addr[i] = 24'($urandom); stim_data[i] = 8'($urandom);
            exp_q.push_back({stim_addr[i], stim_data[i]});
            ioctl_wr = 1'b1; ioctl_addr = {1'b0, stim_addr[i]}; ioctl_dout = stim_data[i];
            tick();
        end
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        tick();
        ioctl_download = 1'b1; ioctl_index = new_idx; ce_drain = 1'b1;
        while (!done && k < 100) begin
            if (idle_n > 0 && dn_busy) done = 1;
            else begin
                if (!ioctl_wait) wait_bad++;
                ndn += int'(dn_wr);
                if (!dn_busy) idle_n++;
                tick();
                k++;
            end
        end
        tests_run++;
        if (!done || wait_bad != 0 || idle_n != 1) begin
            tests_failed++;
            $display("FAIL refire_seq: got restart=%b wait_low=%0d idle_cycles=%0d required 1 0 1", done, wait_bad, idle_n);
        end
        tests_run++;
        if (ndn != 4 || stream_diff() != -1) begin
            tests_failed++; $display("FAIL refire_drain: got %0d strobes required 4", ndn);
        end
        tests_run++;
        if (dn_count !== 25'd0 || dn_index !== new_idx) begin
            tests_failed++; $display("FAIL refire_restart: got cnt=%0d idx=%h required 0 %h", dn_count, dn_index, new_idx);
        end
        drain_to_idle(ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL refire_end: got busy=%b required 0", dn_busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [7:0] new_idx;
        new_idx = 8'($urandom) | 8'h01;
        ce_drain = 1'b0;
        ioctl_index = 8'h80 | 8'($urandom);
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'($urandom) | 25'h1; ioctl_dout = 8'($urandom);
            tick();
        end
        ioctl_wr = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({dn_wr, dn_busy, overflow, dn_addr, dn_data, dn_index, dn_count, dn_sum} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got busy=%b addr=%h data=%h idx=%h cnt=%0d sum=%h required all zero",
                     dn_busy, dn_addr, dn_data, dn_index, dn_count, dn_sum);
        end
        tests_run++;
        if (ioctl_wait !== 1'b1) begin tests_failed++; $display("FAIL midreset_wait: got %b required 1", ioctl_wait); end
        got_q.delete();
        ce_drain = 1'b1;
        ioctl_index = new_idx;
        @(posedge clk_sys); @(posedge clk_sys); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        tests_run++;
        if (got_q.size() != 0) begin
            tests_failed++; $display("FAIL midreset_stale: got %0d strobes required 0", got_q.size());
        end
        tests_run++;
        if (dn_busy !== 1'b1 || dn_index !== new_idx) begin
            tests_failed++; $display("FAIL midreset_restart: got busy=%b idx=%h required 1 %h", dn_busy, dn_index, new_idx);
        end
        drain_to_idle(ok);
        tests_run++;
        if (!ok || dn_count !== 25'd0) begin
            tests_failed++; $display("FAIL midreset_end: got idle=%b cnt=%0d required 1 0", ok, dn_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_checksum();
        test_refire();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/ioctl_dn_buffer.md
# ioctl_dn_buffer

Rate-matching download buffer between the simulation harness's `ioctl_*` byte stream and the `dn_*` download port of `system`. It queues incoming bytes in a small FIFO and applies `ioctl_wait` backpressure. It replays the bytes to `system` at a rate set by a clock-enable, and keeps `dn_busy` high until the last byte has been delivered, so `system` reset covers the whole download. It also reports a byte count, an 8-bit checksum and a sticky overflow flag for bench checking.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; a power of two, at least 4.
- `HEADROOM`, 2: `ioctl_wait` asserts when occupancy ≥ `DEPTH-HEADROOM`; must satisfy 1 ≤ `HEADROOM` < `DEPTH`.

Ports:
- `clk_sys` in 1: system clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ce_drain` in 1: drain enable; at most one byte is popped per high cycle.
- `ioctl_download` in 1: download session active.
- `ioctl_wr` in 1: byte strobe, one cycle per byte.
- `ioctl_addr` in 25: byte address; bits [23:0] are stored.
- `ioctl_dout` in 8: byte data.
- `ioctl_index` in 8: download target index.
- `ioctl_wait` out 1: backpressure to the harness.
- `dn_addr` out 24: replayed address.
- `dn_data` out 8: replayed data.
- `dn_wr` out 1: one-cycle write strobe to `system`.
- `dn_index` out 8: index latched at session start.
- `dn_busy` out 1: session in progress; ORed into `system` reset.
- `dn_count` out 25: bytes delivered this session.
- `dn_sum` out 8: mod-256 sum of delivered data.
- `overflow` out 1: sticky; set when a byte is dropped.

## Operation
- The FIFO holds `DEPTH` entries of {addr[23:0], data[7:0]}. Occupancy is a `log2(DEPTH)+1`-bit register. Pointers wrap modulo `DEPTH`.
- FSM states: IDLE, LOAD, FLUSH.
  - IDLE → LOAD when `ioctl_download`=1. On that transition: latch `ioctl_index` into `dn_index`, and clear `dn_count`, `dn_sum` and `overflow`. The condition is level-sampled, so a session requested during FLUSH starts once IDLE is reached.
  - LOAD → FLUSH when `ioctl_download`=0.
  - FLUSH → IDLE when occupancy is 0 and no `dn_wr` is pending.
- Push: a byte is pushed only in LOAD, when `ioctl_wr`=1 and `ioctl_download`=1.
  - If occupancy = `DEPTH` and no pop happens in the same cycle, the byte is dropped and `overflow` is set.
  - A simultaneous push and pop at full is accepted; occupancy is unchanged.
- `ioctl_wr` with `ioctl_download`=1 in IDLE or FLUSH: the byte is dropped and `overflow` is set.
- `ioctl_wr` with `ioctl_download`=0 is ignored and has no flag effect.
- Pop: in LOAD or FLUSH, when `ce_drain`=1 and occupancy > 0.
  - On the next cycle `dn_addr`/`dn_data` carry the head entry and `dn_wr`=1 for exactly one cycle.
  - On the `dn_wr` cycle, `dn_count` increments and `dn_sum` += `dn_data` (wraps mod 256).
- `ioctl_wait` = (state==FLUSH) | (state==IDLE & `ioctl_download`) | (occupancy ≥ `DEPTH-HEADROOM`). It is combinational from registered state.
- `dn_busy` = (state ≠ IDLE).
- `dn_addr`, `dn_data` and `dn_index` hold their last values between strobes.

## Timing
- Reset (`reset_n`=0, asynchronous) sets all of the following, effective immediately:
  - state IDLE, FIFO empty;
  - `dn_wr`, `dn_busy`, `overflow`, `dn_addr`, `dn_data`, `dn_index`, `dn_count`, `dn_sum` all 0;
  - `ioctl_wait` then follows its equation.
- Reset mid-session discards FIFO contents. After release, a still-high `ioctl_download` starts a new session.
- Latency: `ioctl_wr` at cycle t, with `ce_drain` held high, gives `dn_wr` at t+2. This is the minimum.
- Occupancy, and therefore `ioctl_wait`, reflects a push one cycle after the push. `HEADROOM` ≥ 1 covers the one write the harness may already have in flight.
- Throughput: one byte per `ce_drain` pulse. Back-to-back pulses give back-to-back `dn_wr`.
- `dn_busy` falls on the cycle after the last `dn_wr`. The session ends no earlier than 2 cycles after `ioctl_download` falls.

## Test plan
- Reset, then a session at index 0x01 of 16 bytes (0x00..0x0F at addr 0..15) with `ce_drain` constant 1:
  - `dn_wr` sequence matches the addr/data pairs in order;
  - `dn_count`=16, `dn_sum`=0x78, `overflow`=0;
  - `dn_index`=0x01;
  - `dn_busy` low 1 cycle after the last `dn_wr`.
- `ce_drain` pulse every 4 cycles, harness writing every cycle and honouring `ioctl_wait`, 64 bytes:
  - `ioctl_wait` first rises when occupancy reaches 6;
  - no drops, `dn_count`=64, data order preserved.
- Harness ignores `ioctl_wait` with `ce_drain`=0: 10 writes with `DEPTH`=8 → occupancy 8, `overflow`=1, bytes 9–10 absent from the later drain.
- Write pulse at full with a simultaneous pop → byte accepted, occupancy stays 8, `overflow` stays 0.
- Checksum wrap: bytes 0xFF, 0x02 → `dn_sum`=0x01.
- `ioctl_download` re-raised during FLUSH → `ioctl_wait` stays 1 and the old bytes finish draining. There is one IDLE cycle, then LOAD with `dn_count` cleared to 0 and the new `dn_index` latched.
- `reset_n` pulsed low mid-LOAD with 5 bytes queued → no further `dn_wr`, all outputs 0, and a new session restarts after release.
